// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and sizing helpers for serial_add_ctrl
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: enough to count 0..WIDTH-1, never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - start/busy/done operand bus; sub exists only with SERIAL_ADD_SUB_EN
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// rtl/serial_add_ctrl_fa_cell.sv - combinational 1-bit full adder cell
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic f_o,
  output logic c1_o
);
  assign f_o  = a_i ^ b_i ^ c_i;
  assign c1_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first; SERIAL_ADD_SUB_EN adds subtract mode
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] sum_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             accept;
  logic             fa_b, fa_f, fa_c1;
  logic             load_carry;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
  // Subtract is a + ~b + 1: invert B into the cell and force the initial carry.
  assign fa_b       = b_sh_q[0] ^ sub_q;
  assign load_carry = bus.sub ? 1'b1 : bus.cin;
`else
  assign fa_b       = b_sh_q[0];
  assign load_carry = bus.cin;
`endif

  fa_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (fa_b),
    .c_i  (carry_q),
    .f_o  (fa_f),
    .c1_o (fa_c1)
  );

  // New sum bit enters at the MSB so the LSB-first result ends up aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_f;
    end else begin : g_sum_wn
      assign sum_shift = {fa_f, sum_q[WIDTH-1:1]};
    end
  endgenerate

  assign accept   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Next-state: one cell evaluation per RUN cycle, acceptance from IDLE or DONE restarts.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      ST_RUN: begin
        sum_d   = sum_shift;
        carry_d = fa_c1;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_c1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      carry_d = load_carry;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_d   = bus.sub;
`endif
      state_d = ST_RUN;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Reference: {cout,sum} = a + b + cin, or a + ~b + 1 when subtracting.
  function automatic logic [8:0] model8(logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    logic [7:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + 9'd1;
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  function automatic logic [1:0] model1(logic a, logic b, logic cin, logic sub);
    logic nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + 2'd1;
    return {1'b0, a} + {1'b0, b} + {1'b0, cin};
  endfunction

  task automatic idle_inputs();
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
  endtask

  // Presents an operation and returns at the negedge of the first RUN cycle.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = sub;
`else
    if (sub) $display("FAIL launch8 sub requested without subtract build: got 1 required 0");
`endif
    @(negedge clk);
  endtask

  // Walks the RUN cycles, returns at the negedge of the DONE cycle with start low.
  task automatic run8(input logic [8:0] exp, input bit hold, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (hold) begin bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'h00; end
      else bus8.start = 1'b0;
      if (i == 7) bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
        failures++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, required busy=1 done=0", tag, i, bus8.busy, bus8.done);
      end
      if (i == 0) begin
        checks++;
        if ({bus8.cout, bus8.sum} !== 9'h000) begin
          failures++;
          $display("FAIL %s cleared at acceptance: cout,sum=%h required 000", tag, {bus8.cout, bus8.sum});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0 || {bus8.cout, bus8.sum} !== exp) begin
      failures++;
      $display("FAIL %s done cycle: done=%b busy=%b cout,sum=%h, required done=1 busy=0 cout,sum=%h",
               tag, bus8.done, bus8.busy, {bus8.cout, bus8.sum}, exp);
    end
  endtask

  task automatic idle_after8(input logic [8:0] exp, input string tag);
    bus8.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || {bus8.cout, bus8.sum} !== exp) begin
      failures++;
      $display("FAIL %s after done: done=%b busy=%b cout,sum=%h, required done=0 busy=0 cout,sum=%h",
               tag, bus8.done, bus8.busy, {bus8.cout, bus8.sum}, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0 ||
          bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.sum !== 1'b0 || bus1.cout !== 1'b0) begin
        failures++;
        $display("FAIL reset/idle cycle %0d: w8 busy=%b done=%b sum=%h cout=%b w1 busy=%b done=%b sum=%b cout=%b, required all 0",
                 i, bus8.busy, bus8.done, bus8.sum, bus8.cout, bus1.busy, bus1.done, bus1.sum, bus1.cout);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    launch8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(9'h010, 1'b0, "add_0f_01");
    idle_after8(9'h010, "add_0f_01");
    launch8(8'hFF, 8'h01, 1'b1, 1'b0);
    run8(9'h101, 1'b1, "add_ff_01_cin_start_held");
    idle_after8(9'h101, "add_ff_01_cin_start_held");
  endtask

  task automatic test_back_to_back();
    launch8(8'h80, 8'h80, 1'b0, 1'b0);
    run8(9'h100, 1'b0, "b2b_first");
    launch8(8'h03, 8'h04, 1'b0, 1'b0);
    run8(9'h007, 1'b0, "b2b_second");
    idle_after8(9'h007, "b2b_second");
  endtask

  task automatic test_reset_mid();
    launch8(8'hAA, 8'h55, 1'b0, 1'b0);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || {bus8.cout, bus8.sum} !== 9'h000) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: busy=%b done=%b cout,sum=%h, required 0 0 000",
                 i, bus8.busy, bus8.done, {bus8.cout, bus8.sum});
      end
      @(negedge clk);
    end
    launch8(8'h01, 8'h01, 1'b0, 1'b0);
    run8(9'h002, 1'b0, "after_reset_mid");
    idle_after8(9'h002, "after_reset_mid");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       cin, sub;
    logic [8:0] exp;
    for (int n = 0; n < 40; n++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      exp = model8(a, b, cin, sub);
      launch8(a, b, cin, sub);
      run8(exp, bit'($urandom_range(0, 1)), $sformatf("random_%0d", n));
      if ($urandom_range(0, 1) == 0 || n == 39) begin
        idle_after8(exp, $sformatf("random_%0d", n));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
  endtask

  task automatic op1(input logic a, input logic b, input logic cin, input logic sub, input string tag);
    logic [1:0] exp;
    exp = model1(a, b, cin, sub);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus1.sub = sub;
`endif
    @(negedge clk);
    bus1.start = 1'b0;
    checks++;
    if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
      failures++;
      $display("FAIL %s w1 run: busy=%b done=%b, required 1 0", tag, bus1.busy, bus1.done);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || {bus1.cout, bus1.sum} !== exp) begin
      failures++;
      $display("FAIL %s w1 done: done=%b busy=%b cout,sum=%b, required 1 0 %b",
               tag, bus1.done, bus1.busy, {bus1.cout, bus1.sum}, exp);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || {bus1.cout, bus1.sum} !== exp) begin
      failures++;
      $display("FAIL %s w1 idle: done=%b busy=%b cout,sum=%b, required 0 0 %b",
               tag, bus1.done, bus1.busy, {bus1.cout, bus1.sum}, exp);
    end
  endtask

  task automatic test_width1();
    op1(1'b1, 1'b1, 1'b1, 1'b0, "w1_1p1_cin");
    checks++;
    if ({bus1.cout, bus1.sum} !== 2'b11) begin
      failures++;
      $display("FAIL w1_1p1_cin constant: cout,sum=%b required 11", {bus1.cout, bus1.sum});
    end
    for (int n = 0; n < 12; n++) begin
`ifdef SERIAL_ADD_SUB_EN
      op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("w1_random_%0d", n));
`else
      op1(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, $sformatf("w1_random_%0d", n));
`endif
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    launch8(8'h05, 8'h07, 1'b0, 1'b1);
    run8(9'h0FE, 1'b0, "sub_05_07");
    idle_after8(9'h0FE, "sub_05_07");
    launch8(8'h07, 8'h05, 1'b0, 1'b1);
    run8(9'h102, 1'b0, "sub_07_05");
    idle_after8(9'h102, "sub_07_05");
    op1(1'b1, 1'b1, 1'b0, 1'b1, "w1_sub_1m1");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
